// File: rtl/controller_tc1_period_meter.sv
// Period meter for an external pulse/tach input. The input is synchronized,
// glitch filtered and edge detected; the interval between consecutive rising
// edges is counted in prescaled ticks and published on a registered status
// word whose top bit is a one-cycle update strobe.
module controller_tc1_period_meter #(
  parameter int unsigned PERIOD_W   = 24,
  parameter int unsigned PRESCALE   = 1,
  parameter int unsigned FILTER_LEN = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              sig_in,
  output logic [PERIOD_W:0] status
);

  localparam int unsigned PRE_W = $clog2(PRESCALE) + 1;

  localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(PRESCALE - 1);
  localparam logic [7:0]          RUN_LAST = 8'(FILTER_LEN - 1);
  localparam logic [PERIOD_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARM     = 2'd1,
    S_MEASURE = 2'd2
  } state_t;

  // Input conditioning
  logic r_sync1;
  logic r_sync2;
  logic r_filt;
  logic r_filt_d1;
  logic [7:0] r_run;
  logic r_rise;

  // Measurement datapath
  logic [PRE_W-1:0]    r_pre;
  logic [PERIOD_W-1:0] r_cnt;
  logic [PERIOD_W:0]   r_status;
  state_t              r_state;

  // Combinational
  state_t              w_next;
  logic                w_tick;
  logic [PERIOD_W-1:0] w_meas;
  logic                w_reach;
  logic                w_load;
  logic [PERIOD_W-1:0] w_load_data;
  logic [PERIOD_W-1:0] w_cnt_nxt;

  // Two-flop synchronizer on the asynchronous pulse input
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= sig_in;
      r_sync2 <= r_sync1;
    end
  end

  // Glitch filter: adopt the new level only after FILTER_LEN consecutive
  // disagreeing samples; any agreeing sample restarts the run
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_filt <= 1'b0;
      r_run  <= '0;
    end else if (r_sync2 == r_filt) begin
      r_run <= '0;
    end else if (r_run == RUN_LAST) begin
      r_filt <= r_sync2;
      r_run  <= '0;
    end else begin
      r_run <= r_run + 8'd1;
    end
  end

  // Registered rising-edge detect on the filtered input
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_filt_d1 <= 1'b0;
      r_rise    <= 1'b0;
    end else begin
      r_filt_d1 <= r_filt;
      r_rise    <= r_filt & ~r_filt_d1;
    end
  end

  assign w_tick = (r_state == S_MEASURE) && (r_pre == PRE_LAST);

  // Prescaler runs only while measuring and restarts on every edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pre <= '0;
    end else if ((r_state != S_MEASURE) || r_rise || (r_pre == PRE_LAST)) begin
      r_pre <= '0;
    end else begin
      r_pre <= r_pre + PRE_W'(1);
    end
  end

  // Ticks in (previous rise, now], counting a tick that coincides with now
  assign w_meas  = (r_cnt == CNT_MAX) ? CNT_MAX : (r_cnt + PERIOD_W'(w_tick));
  assign w_reach = (w_meas == CNT_MAX);

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FSM next-state: disable wins, then rise, then timeout
  always_comb begin
    w_next = r_state;
    if (!enable) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:    w_next = S_ARM;
        S_ARM:     if (r_rise) w_next = S_MEASURE;
        S_MEASURE: begin
          if (r_rise) begin
            w_next = S_MEASURE;
          end else if (w_reach) begin
            w_next = S_ARM;
          end
        end
        default:   w_next = S_IDLE;
      endcase
    end
  end

  // FSM outputs: status load decision and next counter value
  always_comb begin
    w_load      = 1'b0;
    w_load_data = w_meas;
    w_cnt_nxt   = r_cnt;
    if (enable && (r_state == S_MEASURE)) begin
      if (r_rise) begin
        w_load      = 1'b1;
        w_load_data = w_meas;
      end else if (w_reach) begin
        w_load      = 1'b1;
        w_load_data = CNT_MAX;
      end
    end
    if ((w_next != S_MEASURE) || r_rise) begin
      w_cnt_nxt = '0;
    end else if (w_tick && (r_cnt != CNT_MAX)) begin
      w_cnt_nxt = r_cnt + PERIOD_W'(1);
    end
  end

  // Period counter and registered status word (strobe is a one-cycle pulse,
  // data holds between updates)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt    <= '0;
      r_status <= '0;
    end else begin
      r_cnt              <= w_cnt_nxt;
      r_status[PERIOD_W] <= w_load;
      if (w_load) begin
        r_status[PERIOD_W-1:0] <= w_load_data;
      end
    end
  end

  assign status = r_status;

endmodule
